// File: rtl/fixed_point_multi_inv_butterfly.sv
// Iterative inverse radix-2 butterfly for the IFFT path.
// Undoes c = a + w*b, d = a - w*b: a = (c+d)/2, b = conj(w)*(c-d)/2.
// One lane is resolved per cycle through a shared 3-multiplier complex multiplier.
//
//   state | meaning
//   IDLE  | ready for a new transaction; recv_rdy=1
//   COMP  | one lane written per cycle, lane counter walks 0..b-1
//   DONE  | results valid (send_val=1), held until send_rdy
module fixed_point_multi_inv_butterfly #(
    parameter int n = 32,
    parameter int d = 16,
    parameter int b = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    output logic         send_val,
    input  logic         send_rdy,
    input  logic [n-1:0] cr [b],
    input  logic [n-1:0] cc [b],
    input  logic [n-1:0] dr [b],
    input  logic [n-1:0] dc [b],
    input  logic [n-1:0] wr [b],
    input  logic [n-1:0] wc [b],
    output logic [n-1:0] ar [b],
    output logic [n-1:0] ac [b],
    output logic [n-1:0] br [b],
    output logic [n-1:0] bc [b]
);

    localparam int LW = (b > 1) ? $clog2(b) : 1;
    // Product width with enough headroom that the Gauss terms never wrap.
    localparam int P  = 2 * n + 4;

    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] lane;
    logic          last_lane;
    logic          accept;

    logic [n-1:0] st_cr [b];
    logic [n-1:0] st_cc [b];
    logic [n-1:0] st_dr [b];
    logic [n-1:0] st_dc [b];
    logic [n-1:0] st_wr [b];
    logic [n-1:0] st_wc [b];

    logic signed [n-1:0] l_cr, l_cc, l_dr, l_dc, l_wr, l_wc;
    logic signed [n:0]   sum_r, sum_i, dif_r, dif_i;
    logic signed [n-1:0] a_r, a_i, h_r, h_i;
    logic signed [P-1:0] m_u, m_v, k1, k2, k3, p_re, p_im;
    logic [n-1:0]        b_r, b_i;

    assign last_lane = (lane == LW'(b - 1));
    assign accept    = (state == IDLE) && recv_val;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        recv_rdy  = 1'b0;
        send_val  = 1'b0;
        case (state)
            IDLE: begin
                recv_rdy = 1'b1;
                if (recv_val) state_nxt = COMP;
            end
            COMP: begin
                if (last_lane) state_nxt = DONE;
            end
            DONE: begin
                send_val = 1'b1;
                if (send_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane counter: cleared on accept, walks through COMP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane <= '0;
        end else if (accept) begin
            lane <= '0;
        end else if (state == COMP) begin
            lane <= last_lane ? '0 : lane + LW'(1);
        end
    end

    // Capture every lane on accept so the input ports are free afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < b; i++) begin
                st_cr[i] <= '0;
                st_cc[i] <= '0;
                st_dr[i] <= '0;
                st_dc[i] <= '0;
                st_wr[i] <= '0;
                st_wc[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < b; i++) begin
                st_cr[i] <= cr[i];
                st_cc[i] <= cc[i];
                st_dr[i] <= dr[i];
                st_dc[i] <= dc[i];
                st_wr[i] <= wr[i];
                st_wc[i] <= wc[i];
            end
        end
    end

    assign l_cr = st_cr[lane];
    assign l_cc = st_cc[lane];
    assign l_dr = st_dr[lane];
    assign l_dc = st_dc[lane];
    assign l_wr = st_wr[lane];
    assign l_wc = st_wc[lane];

    // Lane datapath: halved sum/difference, then h * conj(w) with three multiplies.
    // With u = wr, v = -wc: re = u*(hr+hi) - hi*(u+v), im = u*(hr+hi) + hr*(v-u).
    always_comb begin
        sum_r = (n+1)'(l_cr) + (n+1)'(l_dr);
        sum_i = (n+1)'(l_cc) + (n+1)'(l_dc);
        dif_r = (n+1)'(l_cr) - (n+1)'(l_dr);
        dif_i = (n+1)'(l_cc) - (n+1)'(l_dc);
        a_r   = n'(sum_r >>> 1);
        a_i   = n'(sum_i >>> 1);
        h_r   = n'(dif_r >>> 1);
        h_i   = n'(dif_i >>> 1);
        m_u   = P'(l_wr);
        m_v   = -P'(l_wc);
        k1    = m_u * (P'(h_r) + P'(h_i));
        k2    = P'(h_r) * (m_v - m_u);
        k3    = P'(h_i) * (m_u + m_v);
        p_re  = k1 - k3;
        p_im  = k1 + k2;
        b_r   = n'(p_re >>> d);
        b_i   = n'(p_im >>> d);
    end

    // Result registers: one lane per COMP cycle, held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < b; i++) begin
                ar[i] <= '0;
                ac[i] <= '0;
                br[i] <= '0;
                bc[i] <= '0;
            end
        end else if (state == COMP) begin
            ar[lane] <= a_r;
            ac[lane] <= a_i;
            br[lane] <= b_r;
            bc[lane] <= b_i;
        end
    end

endmodule
